// File: rtl/itrx_aib_phy_tx_lane_ser.sv
// AIB TX lane serializer front end: PRBS7/data select, SDR/DDR phase mux and
// spare-lane redundancy remap with a guarded drain/apply handover.
module itrx_aib_phy_tx_lane_ser #(
   parameter int NLANES = 20,
   parameter int GUARD  = 4,
   parameter int IDXW   = $clog2(NLANES + 1)
) (
   input  logic              ilaunch_clk,
   input  logic              rst_n,
   input  logic [NLANES-1:0] idat0,
   input  logic [NLANES-1:0] idat1,
   input  logic [NLANES-1:0] async_data,
   input  logic              ddr_mode,
   input  logic              prbs_en,
   input  logic              redn_engage,
   input  logic [IDXW-1:0]   redn_fail_idx,
   output logic [NLANES:0]   idat0q,
   output logic [NLANES:0]   idat1q,
   output logic [NLANES:0]   async_phy,
   output logic              redn_busy,
   output logic              map_engaged,
   output logic [IDXW-1:0]   map_idx,
   output logic              cfg_err
);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_APPLY} state_e;

   localparam logic [3:0]      GUARD_M1 = 4'(GUARD - 1);
   localparam logic [IDXW-1:0] MAX_IDX  = IDXW'(NLANES);
   localparam logic [6:0]      SEED     = 7'h7F;

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              req_eng_q, req_eng_d;
   logic [IDXW-1:0]   req_idx_q, req_idx_d;
   logic              map_eng_q, map_eng_d;
   logic [IDXW-1:0]   map_idx_q, map_idx_d;
   logic [6:0]        lfsr_q, lfsr_d;
   logic              prbs_en_q;
   logic              illegal_q;
   logic              cfg_err_q, cfg_err_d;
   logic [NLANES:0]   idat0q_q, idat0q_d, idat1q_q, idat1q_d;

   logic              req_illegal, req_legal, differs_map, differs_held;
   logic [IDXW-1:0]   req_idx_n;
   logic [6:0]        lfsr_cur, lfsr_s1, lfsr_s2;
   logic [NLANES-1:0] odd_mask, log0, log1, prbs_even, prbs_odd;

   // Physical lane p: below the failing lane it carries logical p, the failing
   // lane is forced to 0 and everything above shifts up by one onto the spare.
   function automatic logic [NLANES:0] remap(input logic [NLANES-1:0] lg,
                                             input logic eng,
                                             input logic [IDXW-1:0] f);
      logic [NLANES:0] p;
      p = '0;
      for (int i = 0; i <= NLANES; i++) begin
         if (!eng || i < int'(f)) begin
            if (i < NLANES) p[i] = lg[i];
         end else if (i > int'(f)) begin
            p[i] = lg[i-1];
         end
      end
      return p;
   endfunction

   // An engaged request pointing past the spare is rejected; a disengaged
   // request's index is don't-care, so it is normalised to 0 before comparing.
   always_comb begin
      req_illegal  = redn_engage && (redn_fail_idx > MAX_IDX);
      req_legal    = !req_illegal;
      req_idx_n    = redn_engage ? redn_fail_idx : '0;
      differs_map  = req_legal && ((redn_engage != map_eng_q) ||
                                   (redn_engage && (redn_fail_idx != map_idx_q)));
      differs_held = req_legal && ((redn_engage != req_eng_q) ||
                                   (redn_engage && (redn_fail_idx != req_idx_q)));
   end

   // NOTE: every signal assigned in an always_comb gets a default first, so no
   // path through the case/if tree can leave it unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_eng_d = req_eng_q;
      req_idx_d = req_idx_q;
      map_eng_d = map_eng_q;
      map_idx_d = map_idx_q;
      unique case (state_q)
         ST_RUN: begin
            if (differs_map) begin
               state_d   = ST_DRAIN;
               cnt_d     = '0;
               req_eng_d = redn_engage;
               req_idx_d = req_idx_n;
            end
         end
         ST_DRAIN: begin
            if (differs_held) begin
               cnt_d     = '0;
               req_eng_d = redn_engage;
               req_idx_d = req_idx_n;
            end else if (cnt_q == GUARD_M1) begin
               state_d = ST_APPLY;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         ST_APPLY: begin
            map_eng_d = req_eng_q;
            map_idx_d = req_idx_q;
            state_d   = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      redn_busy   = (state_q != ST_RUN);
      map_engaged = map_eng_q;
      map_idx     = map_idx_q;
      cfg_err     = cfg_err_q;
      idat0q      = idat0q_q;
      idat1q      = idat1q_q;
      async_phy   = remap(async_data, map_eng_q, map_idx_q);
   end

   // PRBS7 (x^7+x^6+1) stepped twice per cycle; a rising prbs_en restarts
   // the sequence from the seed in that same cycle.
   always_comb begin
      lfsr_cur = (prbs_en && !prbs_en_q) ? SEED : lfsr_q;
      lfsr_s1  = {lfsr_cur[5:0], lfsr_cur[6] ^ lfsr_cur[5]};
      lfsr_s2  = {lfsr_s1[5:0], lfsr_s1[6] ^ lfsr_s1[5]};
      lfsr_d   = prbs_en ? lfsr_s2 : lfsr_q;
      for (int l = 0; l < NLANES; l++) odd_mask[l] = l[0];
      prbs_even = {NLANES{lfsr_s1[0]}} ^ odd_mask;
      prbs_odd  = {NLANES{lfsr_s2[0]}} ^ odd_mask;
      if (prbs_en) begin
         log0 = prbs_even;
         log1 = ddr_mode ? prbs_odd : prbs_even;
      end else begin
         log0 = idat0;
         log1 = ddr_mode ? idat1 : idat0;
      end
      cfg_err_d = req_illegal && !illegal_q;
      // Outputs are blanked for every cycle the FSM is away from RUN; the
      // cycle leaving APPLY already launches with the newly applied map.
      idat0q_d  = (state_d == ST_RUN) ? remap(log0, map_eng_d, map_idx_d) : '0;
      idat1q_d  = (state_d == ST_RUN) ? remap(log1, map_eng_d, map_idx_d) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge ilaunch_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_RUN;
         cnt_q     <= '0;
         req_eng_q <= 1'b0;
         req_idx_q <= '0;
         map_eng_q <= 1'b0;
         map_idx_q <= '0;
         lfsr_q    <= SEED;
         prbs_en_q <= 1'b0;
         illegal_q <= 1'b0;
         cfg_err_q <= 1'b0;
         idat0q_q  <= '0;
         idat1q_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_eng_q <= req_eng_d;
         req_idx_q <= req_idx_d;
         map_eng_q <= map_eng_d;
         map_idx_q <= map_idx_d;
         lfsr_q    <= lfsr_d;
         prbs_en_q <= prbs_en;
         illegal_q <= req_illegal;
         cfg_err_q <= cfg_err_d;
         idat0q_q  <= idat0q_d;
         idat1q_q  <= idat1q_d;
      end
   end

endmodule

// File: tb/tb_itrx_aib_phy_tx_lane_ser.sv
// Self-checking bench for itrx_aib_phy_tx_lane_ser: vector table over several
// redundancy maps, handover timing, illegal requests, reset and PRBS7.
module tb_itrx_aib_phy_tx_lane_ser;
   localparam int NL    = 20;
   localparam int GUARD = 4;
   localparam int IW    = $clog2(NL + 1);
   localparam int NVEC  = 10;
   localparam logic [NL-1:0] ODD = 20'hAAAAA;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NL-1:0]   idat0, idat1, async_data;
   logic            ddr_mode, prbs_en, redn_engage;
   logic [IW-1:0]   redn_fail_idx;
   logic [NL:0]     idat0q, idat1q, async_phy;
   logic            redn_busy, map_engaged, cfg_err;
   logic [IW-1:0]   map_idx;

   itrx_aib_phy_tx_lane_ser #(.NLANES(NL), .GUARD(GUARD), .IDXW(IW)) dut (
      .ilaunch_clk(clk), .rst_n(rst_n), .idat0(idat0), .idat1(idat1),
      .async_data(async_data), .ddr_mode(ddr_mode), .prbs_en(prbs_en),
      .redn_engage(redn_engage), .redn_fail_idx(redn_fail_idx),
      .idat0q(idat0q), .idat1q(idat1q), .async_phy(async_phy),
      .redn_busy(redn_busy), .map_engaged(map_engaged), .map_idx(map_idx),
      .cfg_err(cfg_err));

   always #5 clk = ~clk;

   typedef struct {
      logic          ddr;
      logic [NL-1:0] d0;
      logic [NL-1:0] d1;
      logic [NL:0]   exp0;   // expected physical data under the unengaged map
      logic [NL:0]   exp1;
   } vec_t;

   vec_t vecs[NVEC];
   int   n_pass = 0;
   int   n_total = 0;
   logic m_eng = 1'b0;
   int   m_idx = 0;
   bit   seq[0:1023];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference placement: bits below F stay, bit F is empty, bits at/above F
   // move up one position.
   function automatic logic [NL:0] phy(input logic [NL-1:0] lg);
      longint unsigned v, low, high;
      v = 64'(lg);
      if (!m_eng) return {1'b0, lg};
      low  = v & ((64'd1 << m_idx) - 64'd1);
      high = (v >> m_idx) << (m_idx + 1);
      return (NL + 1)'(low | high);
   endfunction

   function automatic logic [NL-1:0] prbs_vec(input bit b);
      return b ? ~ODD : ODD;
   endfunction

   task automatic fill_vecs();
      logic [NL-1:0] a, b;
      vecs[0] = '{1'b1, 20'hAAAAA, 20'h55555, 21'h0AAAAA, 21'h055555};
      vecs[1] = '{1'b0, 20'h00F0F, 20'hFFFFF, 21'h000F0F, 21'h000F0F};
      for (int i = 2; i < NVEC; i++) begin
         a = NL'($urandom);
         b = NL'($urandom);
         vecs[i].ddr  = 1'($urandom);
         vecs[i].d0   = a;
         vecs[i].d1   = b;
         vecs[i].exp0 = {1'b0, a};
         vecs[i].exp1 = {1'b0, vecs[i].ddr ? b : a};
      end
   endtask

   task automatic run_vecs(input string tag);
      logic [NL-1:0] as;
      for (int i = 0; i < NVEC; i++) begin
         ddr_mode   = vecs[i].ddr;
         idat0      = vecs[i].d0;
         idat1      = vecs[i].d1;
         as         = NL'($urandom);
         async_data = as;
         #1;
         check({tag, " async_phy"}, 64'(async_phy), 64'(phy(as)));
         step();
         check({tag, " idat0q"}, 64'(idat0q), 64'(phy(vecs[i].exp0[NL-1:0])));
         check({tag, " idat1q"}, 64'(idat1q), 64'(phy(vecs[i].exp1[NL-1:0])));
      end
   endtask

   // Issue a map change and follow the busy window until it closes.
   task automatic change_map(input logic eng, input int idx, input int exp_busy);
      int busy = 0;
      int cyc = 0;
      redn_engage   = eng;
      redn_fail_idx = IW'(idx);
      while (cyc < 40) begin
         step();
         cyc++;
         if (redn_busy) begin
            busy++;
            check("drain idat0q zero", 64'(idat0q), 64'd0);
            check("drain idat1q zero", 64'(idat1q), 64'd0);
         end else if (busy > 0) begin
            break;
         end
      end
      if (cyc >= 40) check("map change timeout", 64'd1, 64'd0);
      check("busy cycle count", 64'(busy), 64'(exp_busy));
      m_eng = eng;
      m_idx = eng ? idx : 0;
      check("map_engaged", 64'(map_engaged), 64'(m_eng));
      check("map_idx", 64'(map_idx), 64'(m_idx));
   endtask

   initial begin
      int busy, errs, k;
      for (int i = 0; i < 7; i++) seq[i] = 1'b1;
      for (int n = 0; n + 7 < 1024; n++) seq[n+7] = seq[n] ^ seq[n+1];

      rst_n = 1'b0; idat0 = '1; idat1 = '1; async_data = '0; ddr_mode = 1'b1;
      prbs_en = 1'b0; redn_engage = 1'b0; redn_fail_idx = '0;
      #3;
      check("reset idat0q", 64'(idat0q), 64'd0);
      check("reset idat1q", 64'(idat1q), 64'd0);
      check("reset busy", 64'(redn_busy), 64'd0);
      check("reset map_engaged", 64'(map_engaged), 64'd0);
      check("reset map_idx", 64'(map_idx), 64'd0);
      check("reset cfg_err", 64'(cfg_err), 64'd0);
      step(); step();
      rst_n = 1'b1;
      step();

      fill_vecs();
      run_vecs("unengaged");

      // Engage on lane 3 with all-ones data: physical 3 is the only zero.
      ddr_mode = 1'b1; idat0 = '1; idat1 = 20'h80008;
      change_map(1'b1, 3, GUARD + 1);
      check("F3 idat0q placement", 64'(idat0q), 64'h1FFFF7);
      check("F3 idat1q lane3->4, lane19->spare", 64'(idat1q), 64'h100010);
      run_vecs("F3");

      // Illegal request: one pulse, no handover, map untouched.
      redn_engage = 1'b1; redn_fail_idx = IW'(25);
      errs = 0; busy = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         errs += int'(cfg_err);
         busy += int'(redn_busy);
      end
      check("illegal cfg_err pulses", 64'(errs), 64'd1);
      check("illegal busy cycles", 64'(busy), 64'd0);
      check("illegal map_idx", 64'(map_idx), 64'd3);
      redn_fail_idx = IW'(3);
      step();

      change_map(1'b1, NL, GUARD + 1);
      run_vecs("F20");
      change_map(1'b1, 0, GUARD + 1);
      run_vecs("F0");

      // Changing the request two cycles into DRAIN restarts the guard count.
      redn_engage = 1'b1; redn_fail_idx = IW'(5);
      busy = 0;
      step(); busy += int'(redn_busy);
      step(); busy += int'(redn_busy);
      redn_fail_idx = IW'(7);
      k = 0;
      while (k < 40) begin
         step(); k++;
         if (!redn_busy) break;
         busy++;
      end
      check("restart busy cycles", 64'(busy), 64'(GUARD + 3));
      check("restart map_idx", 64'(map_idx), 64'd7);
      m_idx = 7;

      // Reset asserted mid-DRAIN clears everything without a clock.
      idat0 = '1; idat1 = '1;
      redn_engage = 1'b0; redn_fail_idx = '0;
      step(); step();
      check("pre-reset busy", 64'(redn_busy), 64'd1);
      rst_n = 1'b0;
      #1;
      check("async reset idat0q", 64'(idat0q), 64'd0);
      check("async reset idat1q", 64'(idat1q), 64'd0);
      check("async reset busy", 64'(redn_busy), 64'd0);
      check("async reset map_engaged", 64'(map_engaged), 64'd0);
      step();
      rst_n = 1'b1;
      m_eng = 1'b0; m_idx = 0;
      step(); step();
      check("post-reset map_engaged", 64'(map_engaged), 64'd0);
      check("post-reset busy", 64'(redn_busy), 64'd0);
      check("post-reset idat0q", 64'(idat0q), 64'h0FFFFF);

      // PRBS7 in DDR for a full period and beyond, then SDR, then restart.
      ddr_mode = 1'b1; prbs_en = 1'b1; idat0 = NL'($urandom);
      k = 0;
      for (int c = 0; c < 130; c++) begin
         step();
         check("prbs ddr even", 64'(idat0q), 64'(phy(prbs_vec(seq[k+7]))));
         check("prbs ddr odd", 64'(idat1q), 64'(phy(prbs_vec(seq[k+8]))));
         k += 2;
      end
      ddr_mode = 1'b0;
      for (int c = 0; c < 8; c++) begin
         step();
         check("prbs sdr even", 64'(idat0q), 64'(phy(prbs_vec(seq[k+7]))));
         check("prbs sdr odd", 64'(idat1q), 64'(phy(prbs_vec(seq[k+7]))));
         k += 2;
      end
      prbs_en = 1'b0; ddr_mode = 1'b1;
      step(); step(); step();
      prbs_en = 1'b1;
      k = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         check("prbs restart even", 64'(idat0q), 64'(phy(prbs_vec(seq[k+7]))));
         check("prbs restart odd", 64'(idat1q), 64'(phy(prbs_vec(seq[k+8]))));
         k += 2;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
